sram_bus_slave: RTL and testbench

SRAM_BUS_SLAVE -- requirements
Module: sram_bus_slave

---
 rtl/sram_bus_pkg.sv | 13 +
 rtl/sram_byte_lane.sv | 39 +++
 rtl/sram_bus_slave.sv | 111 +++++++++++
 tb/tb_sram_bus_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the 32-bit SRAM bus slave.
package sram_bus_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned LANE_W    = 8;
   localparam int unsigned DATA_W    = NUM_LANES * LANE_W;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

endpackage

// File: rtl/sram_byte_lane.sv
// One byte lane of the array: one write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old byte.
module sram_byte_lane
   import sram_bus_pkg::*;
#(
   parameter  int unsigned DEPTH = 1024,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [LANE_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [LANE_W-1:0] rdata_o
);

   logic [LANE_W-1:0] mem_q [DEPTH];
   logic [LANE_W-1:0] rdata_q;

   // Storage is never reset; zeroing is done by the parent's clear sequence.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bus_slave.sv
// Word-addressed SRAM slave with byte enables, optional zero-fill after reset
// and optional same-cycle write-to-read forwarding.
module sram_bus_slave
   import sram_bus_pkg::*;
#(
   parameter int unsigned ADDR_BITS      = 12,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter bit          FWD_EN         = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_req_i,
   output logic                 rd_gnt_o,
   input  logic [31:0]          rd_addr_i,
   output logic [DATA_W-1:0]    rd_data_o,
   input  logic                 wr_req_i,
   output logic                 wr_gnt_o,
   input  logic [31:0]          wr_addr_i,
   input  logic [DATA_W-1:0]    wr_data_i,
   input  logic [NUM_LANES-1:0] wr_be_i,
   output logic                 o_init_done
);

   localparam int unsigned IDX_W = ADDR_BITS - 2;
   localparam int unsigned DEPTH = 2 ** IDX_W;

   state_e                 state_q;
   logic [IDX_W-1:0]       clr_idx_q;
   logic                   init_done_q;
   logic [NUM_LANES-1:0]   fwd_sel_q, fwd_sel_d;
   logic [DATA_W-1:0]      fwd_data_q;
   logic                   ready, clearing;
   logic [IDX_W-1:0]       rd_idx, wr_idx, lane_waddr;
   logic [NUM_LANES-1:0]   lane_we;
   logic [DATA_W-1:0]      lane_wdata, lane_rdata;
   logic                   unused_addr_bits;

   assign rd_idx   = rd_addr_i[ADDR_BITS-1:2];
   assign wr_idx   = wr_addr_i[ADDR_BITS-1:2];
   assign ready    = (state_q == READY) && !rst;
   assign clearing = (state_q == CLEAR) && !rst;

   assign rd_gnt_o    = rd_req_i && ready;
   assign wr_gnt_o    = wr_req_i && ready;
   assign o_init_done = init_done_q;

   // Byte-offset and upper address bits alias onto the same word.
   assign unused_addr_bits = ^{rd_addr_i[31:ADDR_BITS], rd_addr_i[1:0],
                               wr_addr_i[31:ADDR_BITS], wr_addr_i[1:0]};

   // Clear sweep: one word per cycle, READY after the last word is zeroed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR_ON_RESET ? CLEAR : READY;
         clr_idx_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clr_idx_q <= clr_idx_q + 1'b1;
               if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                  state_q     <= READY;
                  init_done_q <= 1'b1;
               end
            end
            READY: begin
               init_done_q <= 1'b1;
            end
            default: begin
               state_q <= CLEAR;
            end
         endcase
      end
   end

   // Forward lanes only for a same-word write granted alongside the read.
   assign fwd_sel_d = (FWD_EN && wr_gnt_o && (wr_idx == rd_idx)) ? wr_be_i : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_sel_q  <= '0;
         fwd_data_q <= '0;
      end else if (rd_gnt_o) begin
         fwd_sel_q  <= fwd_sel_d;
         fwd_data_q <= wr_data_i;
      end
   end

   assign lane_we    = clearing ? '1 : (wr_gnt_o ? wr_be_i : '0);
   assign lane_waddr = clearing ? clr_idx_q : wr_idx;
   assign lane_wdata = clearing ? '0 : wr_data_i;

   for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
      sram_byte_lane #(
         .DEPTH (DEPTH)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .we_i    (lane_we[b]),
         .waddr_i (lane_waddr),
         .wdata_i (lane_wdata[b*LANE_W +: LANE_W]),
         .re_i    (rd_gnt_o),
         .raddr_i (rd_idx),
         .rdata_o (lane_rdata[b*LANE_W +: LANE_W])
      );

      assign rd_data_o[b*LANE_W +: LANE_W] = fwd_sel_q[b] ? fwd_data_q[b*LANE_W +: LANE_W]
                                                          : lane_rdata[b*LANE_W +: LANE_W];
   end

endmodule

// File: tb/tb_sram_bus_slave.sv
// Bench for sram_bus_slave: two configurations, a word-array reference model
// and a scoreboard monitor comparing every read response and idle hold.
module tb_sram_bus_slave;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        rd_req    [2];
   logic        rd_gnt    [2];
   logic [31:0] rd_addr   [2];
   logic [31:0] rd_data   [2];
   logic        wr_req    [2];
   logic        wr_gnt    [2];
   logic [31:0] wr_addr   [2];
   logic [31:0] wr_data   [2];
   logic [3:0]  wr_be     [2];
   logic        init_done [2];

   always #5 clk = ~clk;

   sram_bus_slave #(.ADDR_BITS(6), .CLEAR_ON_RESET(1'b1), .FWD_EN(1'b1)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .rd_req_i(rd_req[0]), .rd_gnt_o(rd_gnt[0]), .rd_addr_i(rd_addr[0]), .rd_data_o(rd_data[0]),
      .wr_req_i(wr_req[0]), .wr_gnt_o(wr_gnt[0]), .wr_addr_i(wr_addr[0]), .wr_data_i(wr_data[0]),
      .wr_be_i(wr_be[0]), .o_init_done(init_done[0]));

   sram_bus_slave #(.ADDR_BITS(12), .CLEAR_ON_RESET(1'b0), .FWD_EN(1'b0)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .rd_req_i(rd_req[1]), .rd_gnt_o(rd_gnt[1]), .rd_addr_i(rd_addr[1]), .rd_data_o(rd_data[1]),
      .wr_req_i(wr_req[1]), .wr_gnt_o(wr_gnt[1]), .wr_addr_i(wr_addr[1]), .wr_data_i(wr_data[1]),
      .wr_be_i(wr_be[1]), .o_init_done(init_done[1]));

   // Reference model: per-instance word arrays and configuration.
   int unsigned depth_m [2] = '{16, 1024};
   int unsigned abits_m [2] = '{6, 12};
   bit          fwd_m   [2] = '{1'b1, 1'b0};
   logic [31:0] mem_m   [2][1024];
   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (new_w & mask) | (old_w & ~mask);
   endfunction

   function automatic int unsigned word_of(input int k, input logic [31:0] a);
      return (a / 4) % depth_m[k];
   endfunction

   function automatic void push_exp(input int k, input logic [31:0] v);
      if (k == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
   endfunction

   // Monitor: each negedge judges the output produced by the previous edge.
   bit          prev_gnt [2] = '{1'b0, 1'b0};
   bit          prev_rst [2] = '{1'b1, 1'b1};
   logic [31:0] last_rd  [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [31:0] e;
         if (prev_rst[k]) begin
            check($sformatf("rst_rd_data%0d", k), rd_data[k], 32'h0);
            last_rd[k] = 32'h0;
         end else if (prev_gnt[k]) begin
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
               check($sformatf("unexpected_rd%0d", k), 32'h1, 32'h0);
            end else begin
               e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               check($sformatf("rd_data%0d", k), rd_data[k], e);
               last_rd[k] = e;
            end
         end else begin
            check($sformatf("hold%0d", k), rd_data[k], last_rd[k]);
         end
         if (rst[k]) check($sformatf("gnt_in_rst%0d", k), {30'h0, rd_gnt[k], wr_gnt[k]}, 32'h0);
         prev_gnt[k] = rd_gnt[k];
         prev_rst[k] = rst[k];
      end
   end

   // Drive one request (read and/or write), hold until granted, update the model.
   task automatic op(input int k, input bit rd, input logic [31:0] ra,
                     input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, output int waits, output int low_cycles);
      logic [31:0] e;
      int unsigned ri, wi;
      rd_req[k] = rd; rd_addr[k] = ra;
      wr_req[k] = wr; wr_addr[k] = wa; wr_data[k] = wd; wr_be[k] = be;
      waits = 0; low_cycles = 0;
      forever begin
         @(negedge clk);
         if (!init_done[k]) low_cycles++;
         if ((rd && rd_gnt[k]) || (wr && wr_gnt[k])) break;
         waits++;
         if (waits > 200) begin
            check($sformatf("grant_timeout%0d", k), 32'h1, 32'h0);
            break;
         end
         @(posedge clk); #1;
      end
      if (waits <= 200) begin
         ri = word_of(k, ra);
         wi = word_of(k, wa);
         if (rd) begin
            e = mem_m[k][ri];
            if (wr && fwd_m[k] && ri == wi) e = merge(e, wd, be);
            push_exp(k, e);
         end
         if (wr) mem_m[k][wi] = merge(mem_m[k][wi], wd, be);
      end
      @(posedge clk); #1;
      rd_req[k] = 1'b0; wr_req[k] = 1'b0;
   endtask

   task automatic wr_op(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int w, l;
      op(k, 1'b0, 32'h0, 1'b1, a, d, be, w, l);
   endtask

   task automatic rd_op(input int k, input logic [31:0] a);
      int w, l;
      op(k, 1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0, w, l);
   endtask

   // Checks rd_data in the cycle right after an op returns, against a constant.
   task automatic check_now(input string nm, input int k, input logic [31:0] exp_v);
      @(negedge clk);
      check(nm, rd_data[k], exp_v);
      @(posedge clk); #1;
   endtask

   task automatic zero_model(input int k);
      for (int i = 0; i < 1024; i++) mem_m[k][i] = 32'h0;
   endtask

   function automatic logic [31:0] rand_addr(input int k);
      logic [31:0] up, lo;
      up = $urandom << abits_m[k];
      lo = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      return up | lo;
   endfunction

   initial begin
      int w, l;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; rd_req[k] = 1'b0; wr_req[k] = 1'b0;
         rd_addr[k] = '0; wr_addr[k] = '0; wr_data[k] = '0; wr_be[k] = '0;
      end
      zero_model(0);
      @(posedge clk); #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Initial clear: 16 cycles without grant, then reads see zero.
      op(0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, w, l);
      check("init_clear_waits", 32'(w), 32'd16);
      check("init_clear_low", 32'(l), 32'd16);

      // Fill with ones, reset mid-READY, expect a full re-clear.
      for (int i = 0; i < 16; i++) wr_op(0, 32'(i * 4), 32'hFFFF_FFFF, 4'hF);
      rst[0] = 1'b1; @(posedge clk); #1; rst[0] = 1'b0;
      zero_model(0);
      op(0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, w, l);
      check("reclear_waits", 32'(w), 32'd16);
      check("reclear_low", 32'(l), 32'd16);
      for (int i = 1; i < 16; i++) rd_op(0, 32'(i * 4));

      // Byte-lane merge.
      wr_op(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
      wr_op(0, 32'h10, 32'h0000_AA00, 4'h2);
      rd_op(0, 32'h10);
      check_now("be_merge", 0, 32'hDEAD_AAEF);
      wr_op(0, 32'h14, 32'h5555_5555, 4'h0);
      rd_op(0, 32'h14);
      check_now("be_zero", 0, 32'h0);

      // Same-word read/write collision, forwarding on and off.
      for (int k = 0; k < 2; k++) begin
         wr_op(k, 32'h20, 32'hAABB_CCDD, 4'hF);
         op(k, 1'b1, 32'h20, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, w, l);
         check_now($sformatf("collide%0d", k), k, (k == 0) ? 32'hAA22_CC44 : 32'hAABB_CCDD);
         rd_op(k, 32'h20);
         check_now($sformatf("after_collide%0d", k), k, 32'hAA22_CC44);
      end

      // Aliasing of upper address bits and rd_data hold over idle cycles.
      wr_op(1, 32'h0000_1004, 32'h1234_5678, 4'hF);
      rd_op(1, 32'h0000_0004);
      check_now("alias1", 1, 32'h1234_5678);
      repeat (4) @(posedge clk);
      #1;
      wr_op(0, 32'hFFFF_FFC4, 32'h0BAD_F00D, 4'hF);
      rd_op(0, 32'h0000_0006);
      check_now("alias0", 0, 32'h0BAD_F00D);

      // Read and write to different words in one cycle.
      op(0, 1'b1, 32'h10, 1'b1, 32'h18, 32'h7777_8888, 4'hF, w, l);
      check("diff_word_waits", 32'(w), 32'd0);
      rd_op(0, 32'h18);

      // Prefill the first 16 words of the uncleared instance, then random traffic.
      for (int i = 0; i < 16; i++) wr_op(1, 32'(i * 4), $urandom, 4'hF);
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 150; n++) begin
            bit rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) begin
               @(posedge clk); #1;
            end else begin
               op(k, rd, rand_addr(k), wr, rand_addr(k), $urandom, 4'($urandom_range(0, 15)), w, l);
            end
         end
      end

      // Reset at clear cycle 5 restarts the sweep; held read waits the full sweep.
      rst[0] = 1'b1; @(posedge clk); #1; rst[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst[0] = 1'b1; rd_req[0] = 1'b1; rd_addr[0] = 32'h24;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      zero_model(0);
      op(0, 1'b1, 32'h24, 1'b0, 32'h0, 32'h0, 4'h0, w, l);
      check("restart_waits", 32'(w), 32'd16);
      check_now("restart_rd", 0, 32'h0);

      // Without clear-on-reset, contents survive and the slave is ready at once.
      wr_op(1, 32'h8, 32'hCAFE_F00D, 4'hF);
      rst[1] = 1'b1; @(posedge clk); #1; rst[1] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("keep_init_done", {31'h0, init_done[1]}, 32'h1);
      @(posedge clk); #1;
      rd_op(1, 32'h8);
      check_now("keep_contents", 1, 32'hCAFE_F00D);
      for (int i = 0; i < 16; i++) rd_op(1, 32'(i * 4));

      repeat (3) @(posedge clk);
      #1;
      check("queue0_drained", 32'(exp_q0.size()), 32'h0);
      check("queue1_drained", 32'(exp_q1.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
